antirrebote_sensores: RTL and testbench

Dual-channel input conditioner for the two parking-barrier photo sensors. Synchronizes raw sensor lines `a_raw`/`b_raw` into the system clock domain, rejects contact and optical bounce, and delivers clean levels `a`/`b` directly to `fsm_estacionamiento`, which relies on every sensor transition being a single clean edge. Also emits one-cycle change pulses for diagnostics and counting logic.

---
 rtl/antirrebote_sensores_pkg.sv | 23 ++
 rtl/antirrebote_canal.sv | 66 ++++++
 rtl/antirrebote_sensores.sv | 42 ++++
 tb/tb_antirrebote_sensores.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/antirrebote_sensores_pkg.sv
// Shared definitions for the parking-barrier sensor conditioner.
// Holds the per-channel decision codes and the helper that picks one.
package antirrebote_sensores_pkg;

  // Channel decision codes, one per rising edge
  localparam logic [1:0] ST_STABLE  = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ACCEPT  = 2'd2;

  // Chooses the decision for this edge: a differing level either keeps
  // counting or, once the count has reached its last value, is accepted.
  function automatic logic [1:0] clasificar(input logic nivel_distinto,
                                            input logic cuenta_completa);
    logic [1:0] st;
    st = ST_STABLE;
    if (nivel_distinto) begin
      if (cuenta_completa) st = ST_ACCEPT;
      else                 st = ST_PENDING;
    end
    return st;
  endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// One debounced sensor channel: 2-FF synchronizer, hold counter, clean
// output level and a one-cycle change pulse. A new level must be seen on
// the synchronized line for STABLE_CYCLES consecutive edges to be taken.
module antirrebote_canal
  import antirrebote_sensores_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic d,
  output logic flanco
);

  // Last count value; reaching it with the level still differing accepts it
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       estado;

  // Two-stage synchronizer bringing the asynchronous sensor line into clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d_raw;
      s2 <= s1;
    end
  end

  // Decide whether the synchronized level agrees, is being timed, or wins
  always_comb begin
    estado = clasificar(s2 != d, cnt == CNT_MAX);
  end

  // Hold counter, output level and change pulse; any return to the current
  // level clears the count so a bounce always restarts timing from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      d      <= 1'b0;
      flanco <= 1'b0;
    end else begin
      flanco <= 1'b0;
      case (estado)
        ST_PENDING: begin
          cnt <= cnt + CNT_W'(1);
        end
        ST_ACCEPT: begin
          cnt    <= '0;
          d      <= s2;
          flanco <= 1'b1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/antirrebote_sensores.sv
// Dual-channel conditioner for the outer (a) and inner (b) barrier photo
// sensors. Each channel is debounced independently; both may change in the
// same cycle and neither has priority over the other.
module antirrebote_sensores
  import antirrebote_sensores_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_flanco,
  output logic b_flanco
);

  antirrebote_canal #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_canal_a (
    .clk   (clk),
    .reset (reset),
    .d_raw (a_raw),
    .d     (a),
    .flanco(a_flanco)
  );

  antirrebote_canal #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_canal_b (
    .clk   (clk),
    .reset (reset),
    .d_raw (b_raw),
    .d     (b),
    .flanco(b_flanco)
  );

endmodule

// File: tb/tb_antirrebote_sensores.sv
// Bench for antirrebote_sensores with a short hold time. A reference model
// accepts a new level once the last S synchronized samples all differ from
// the current output; table vectors, hand sequences and random stimulus are
// all compared against it and against fixed expectations.
module tb_antirrebote_sensores;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  logic a_raw, b_raw;
  logic a, b, a_flanco, b_flanco;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit ma, mb, mfa, mfb;
  bit sa1, sa2, sb1, sb2;
  bit qa[$];
  bit qb[$];

  // observed clean (a,b) sequence for the car scenarios
  bit         track_seq = 0;
  logic [1:0] last_ab;
  logic [1:0] obs_seq[$];

  typedef struct {
    logic ar;
    logic br;
    int   n;
    logic ea;
    logic eb;
    logic efa;
    logic efb;
  } vec_t;

  vec_t tbl[10];

  always #10 clk = ~clk;

  antirrebote_sensores #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_raw   (a_raw),
    .b_raw   (b_raw),
    .a       (a),
    .b       (b),
    .a_flanco(a_flanco),
    .b_flanco(b_flanco)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, wanted %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit accept_now(input bit q[$], input bit cur);
    if (q.size() != S) return 1'b0;
    foreach (q[i]) if (q[i] == cur) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    ma = 0; mb = 0; mfa = 0; mfb = 0;
    sa1 = 0; sa2 = 0; sb1 = 0; sb2 = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    qa.push_back(sa2);
    if (qa.size() > S) void'(qa.pop_front());
    qb.push_back(sb2);
    if (qb.size() > S) void'(qb.pop_front());
    mfa = accept_now(qa, ma);
    mfb = accept_now(qb, mb);
    if (mfa) ma = ~ma;
    if (mfb) mb = ~mb;
    sa2 = sa1; sa1 = a_raw;
    sb2 = sb1; sb1 = b_raw;
  endtask

  task automatic checkOutput();
    check("model_a", a, ma);
    check("model_b", b, mb);
    check("model_a_flanco", a_flanco, mfa);
    check("model_b_flanco", b_flanco, mfb);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput();
    if (track_seq && ({a, b} != last_ab)) begin
      obs_seq.push_back({a, b});
      last_ab = {a, b};
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic br, input int n);
    a_raw = ar;
    b_raw = br;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ticks n edges, reports first edge each output changed and pulse counts
  task automatic watch(input int n, output int chg_a, output int chg_b,
                       output int pa, output int pb);
    logic a0, b0;
    a0 = a; b0 = b;
    chg_a = 0; chg_b = 0; pa = 0; pb = 0;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (chg_a == 0 && a !== a0) chg_a = e;
      if (chg_b == 0 && b !== b0) chg_b = e;
      if (a_flanco === 1'b1) pa++;
      if (b_flanco === 1'b1) pb++;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_a", a, 1'b0);
    check("async_rst_a_flanco", a_flanco, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  // net car count from a clean (a,b) sequence: entry 10,11,01,00; exit mirrored
  function automatic int count_cars(input logic [1:0] seq[$]);
    int n;
    n = 0;
    for (int i = 0; i + 3 < seq.size(); i++) begin
      if (seq[i] == 2'b10 && seq[i+1] == 2'b11 && seq[i+2] == 2'b01 && seq[i+3] == 2'b00) n++;
      if (seq[i] == 2'b01 && seq[i+1] == 2'b11 && seq[i+2] == 2'b10 && seq[i+3] == 2'b00) n--;
    end
    return n;
  endfunction

  task automatic car_step(input logic [1:0] prev, input logic [1:0] nxt);
    applyStimulus(nxt[1], nxt[0], 1);
    applyStimulus(prev[1], prev[0], 1);
    applyStimulus(nxt[1], nxt[0], 8);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int ca, cb, pa, pb;
    int run_a, run_b;
    logic [1:0] exp_entry[4];

    tbl[0] = '{1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b1};

    // reset held with both sensors active
    reset = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;
    model_reset();
    #1;
    check("rst_a", a, 1'b0);
    check("rst_b", b, 1'b0);
    check("rst_a_flanco", a_flanco, 1'b0);
    check("rst_b_flanco", b_flanco, 1'b0);
    tick();
    tick();
    check("rst_hold_a", a, 1'b0);
    check("rst_hold_b", b, 1'b0);
    reset = 1'b1;
    watch(10, ca, cb, pa, pb);
    check_int("rst_rise_edge_a", ca, S + 2);
    check_int("rst_rise_edge_b", cb, S + 2);
    check_int("rst_pulses_a", pa, 1);
    check_int("rst_pulses_b", pb, 1);
    applyStimulus(1'b0, 1'b0, 10);

    // clean step up and down on a
    a_raw = 1'b1;
    watch(10, ca, cb, pa, pb);
    check_int("step_up_edge", ca, S + 2);
    check_int("step_up_pulses", pa, 1);
    check_int("step_b_untouched", cb + pb, 0);
    a_raw = 1'b0;
    watch(10, ca, cb, pa, pb);
    check_int("step_down_edge", ca, S + 2);
    check_int("step_down_pulses", pa, 1);

    // table vectors, starting from a settled 00
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].ar, tbl[i].br, tbl[i].n);
      check($sformatf("tbl%0d_a", i), a, tbl[i].ea);
      check($sformatf("tbl%0d_b", i), b, tbl[i].eb);
      check($sformatf("tbl%0d_a_flanco", i), a_flanco, tbl[i].efa);
      check($sformatf("tbl%0d_b_flanco", i), b_flanco, tbl[i].efb);
    end

    // bounce on a: 1,0,1,0 with short levels, then held 1
    pa = 0; ca = 0;
    a_raw = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); pa += a_flanco; ca += a; end
    a_raw = 1'b0;
    tick(); pa += a_flanco; ca += a;
    a_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); pa += a_flanco; ca += a; end
    a_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(); pa += a_flanco; ca += a; end
    check_int("bounce_no_early_a", ca + pa, 0);
    a_raw = 1'b1;
    watch(12, ca, cb, pa, pb);
    check_int("bounce_rise_edge", ca, S + 2);
    check_int("bounce_pulses", pa, 1);
    applyStimulus(1'b0, 1'b0, 10);

    // short glitch on b
    pb = 0;
    b_raw = 1'b1;
    for (int i = 0; i < S - 1; i++) begin tick(); pb += b_flanco; end
    b_raw = 1'b0;
    watch(10, ca, cb, pa, pb);
    check_int("glitch_b_change", cb, 0);
    check_int("glitch_b_pulses", pb, 0);

    // reset mid-count on a
    a_raw = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("midrst_before_a", a, 1'b0);
    reset_pulse();
    watch(10, ca, cb, pa, pb);
    check_int("midrst_rise_edge", ca, S + 2);
    check_int("midrst_pulses", pa, 1);
    applyStimulus(1'b0, 1'b0, 10);

    // full car entry, then mirrored exit
    exp_entry[0] = 2'b10; exp_entry[1] = 2'b11;
    exp_entry[2] = 2'b01; exp_entry[3] = 2'b00;
    obs_seq.delete();
    last_ab = {a, b};
    track_seq = 1;
    car_step(2'b00, 2'b10);
    car_step(2'b10, 2'b11);
    car_step(2'b11, 2'b01);
    car_step(2'b01, 2'b00);
    check_int("entry_seq_len", obs_seq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs_seq.size()) check_int($sformatf("entry_seq%0d", i), obs_seq[i], exp_entry[i]);
    check_int("entry_cantidad", count_cars(obs_seq), 1);
    car_step(2'b00, 2'b01);
    car_step(2'b01, 2'b11);
    car_step(2'b11, 2'b10);
    car_step(2'b10, 2'b00);
    check_int("exit_seq_len", obs_seq.size(), 8);
    check_int("exit_cantidad", count_cars(obs_seq), 0);
    track_seq = 0;

    // random stimulus against the model, with occasional resets
    run_a = 0; run_b = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_a == 0) begin a_raw = 1'($urandom_range(0, 1)); run_a = $urandom_range(1, 8); end
      if (run_b == 0) begin b_raw = 1'($urandom_range(0, 1)); run_b = $urandom_range(1, 8); end
      run_a--; run_b--;
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
